// File: rtl/trigger_capture_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// trigger_capture_ctrl_pkg
// Shared types and constants for the trigger/capture controller:
//   state_t      - capture FSM state, encoded as it appears on state_o
//   EDGE_RISING  - edge_sel value selecting a rising-edge level trigger
//   EDGE_FALLING - edge_sel value selecting a falling-edge level trigger
// -----------------------------------------------------------------------------
package trigger_capture_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PREFILL   = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_POST      = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  localparam logic EDGE_RISING  = 1'b0;
  localparam logic EDGE_FALLING = 1'b1;

endpackage

// File: rtl/trigger_capture_ctrl_trig_detect.sv
// -----------------------------------------------------------------------------
// trig_detect
// Level-crossing detector. Remembers the previous valid sample since the last
// clear and flags a crossing of the live trigger level by the current sample.
// Ports:
//   clk, rstn    - clock, synchronous active-low reset
//   clear        - forget the previous sample (arm / abort)
//   sample_valid - sample is part of an active capture
//   sample       - current unsigned sample
//   level        - trigger level (live)
//   edge_sel     - 0 rising (prev < level <= cur), 1 falling (prev >= level > cur)
//   hit          - combinational: current sample crosses the level
// -----------------------------------------------------------------------------
module trig_detect
  import trigger_capture_ctrl_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clear,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] level,
  input  logic              edge_sel,
  output logic              hit
);

  logic [DATA_W-1:0] prev_q;
  logic              prev_vld_q;

  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
    end else if (sample_valid) begin
      prev_q     <= sample;
      prev_vld_q <= 1'b1;
    end
  end

  // Without a previous sample there is no edge, so the first sample after
  // arm can never trigger on level.
  always_comb begin
    hit = 1'b0;
    if (prev_vld_q) begin
      if (edge_sel == EDGE_RISING)
        hit = (prev_q < level) && (level <= sample);
      else
        hit = (prev_q >= level) && (level > sample);
    end
  end

endmodule

// File: rtl/trigger_capture_ctrl.sv
// -----------------------------------------------------------------------------
// trigger_capture_ctrl
// Oscilloscope-style capture controller. After arm it fills pretrig samples,
// waits for a level/forced (optionally auto) trigger, then writes the rest of
// a DEPTH-sample window into an external circular capture buffer.
// Optional feature macro: TRIG_AUTO_EN (auto-trigger after AUTO_TIMEOUT valid
// samples without a trigger). Undefined: WAIT_TRIG waits forever.
// Ports:
//   clk, rstn                       - clock, synchronous active-low reset
//   sample_i, sample_valid_i        - unsigned sample and its one-cycle strobe
//   arm_i, abort_i, force_i         - start capture, return to IDLE, force trigger
//   level_i, edge_sel_i, pretrig_i  - trigger level, edge select, pre-trigger count
//   wr_en_o, wr_addr_o, wr_data_o   - capture buffer write port
//   trig_addr_o                     - buffer address of the trigger sample
//   state_o, busy_o, done_o         - status
//   trig_auto_o                     - last trigger came from the timeout
// -----------------------------------------------------------------------------
module trigger_capture_ctrl
  import trigger_capture_ctrl_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 10,
  parameter int AUTO_TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] sample_i,
  input  logic              sample_valid_i,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic              force_i,
  input  logic [DATA_W-1:0] level_i,
  input  logic              edge_sel_i,
  input  logic [ADDR_W-1:0] pretrig_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic [ADDR_W-1:0] trig_addr_o,
  output logic [2:0]        state_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              trig_auto_o
);

  if (AUTO_TIMEOUT < 1) begin : g_bad_auto_timeout
    $error("AUTO_TIMEOUT must be at least 1");
  end

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] pretrig_q;
  logic [ADDR_W-1:0] post_left_q;
  logic              force_pend_q;

  logic capturing;
  logic arm_ok;
  logic do_write;
  logic hit;
  logic auto_due;
  logic trig_fire;

  assign capturing = (state_q == ST_PREFILL) || (state_q == ST_WAIT_TRIG) ||
                     (state_q == ST_POST);
  assign arm_ok    = arm_i && !abort_i &&
                     ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // POST with nothing left to write only waits one cycle to enter DONE, so a
  // sample arriving then is not part of the window.
  assign do_write  = sample_valid_i && !abort_i && capturing &&
                     !((state_q == ST_POST) && (post_left_q == '0));

  assign trig_fire = do_write && (state_q == ST_WAIT_TRIG) &&
                     (hit || force_i || force_pend_q || auto_due);

  trig_detect #(
    .DATA_W (DATA_W)
  ) u_trig_detect (
    .clk          (clk),
    .rstn         (rstn),
    .clear        (arm_ok || abort_i),
    .sample_valid (sample_valid_i && capturing && !abort_i),
    .sample       (sample_i),
    .level        (level_i),
    .edge_sel     (edge_sel_i),
    .hit          (hit)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      pretrig_q    <= '0;
      post_left_q  <= '0;
      force_pend_q <= 1'b0;
      wr_en_o      <= 1'b0;
      wr_addr_o    <= '0;
      wr_data_o    <= '0;
      trig_addr_o  <= '0;
    end else begin
      wr_en_o <= 1'b0;

      if (do_write) begin
        wr_en_o   <= 1'b1;
        wr_data_o <= sample_i;
        wr_addr_o <= addr_q;
        addr_q    <= addr_q + 1'b1;
      end

      if (abort_i) begin
        state_q      <= ST_IDLE;
        force_pend_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE, ST_DONE: begin
            if (arm_i) begin
              // pretrig_i is ADDR_W bits, so it is already within DEPTH-1.
              pretrig_q    <= pretrig_i;
              addr_q       <= '0;
              wr_addr_o    <= '0;
              force_pend_q <= 1'b0;
              state_q      <= (pretrig_i == '0) ? ST_WAIT_TRIG : ST_PREFILL;
            end
          end
          ST_PREFILL: begin
            // Addresses start at 0, so addr_q is the count already written.
            if (do_write && (addr_q == pretrig_q - 1'b1))
              state_q <= ST_WAIT_TRIG;
          end
          ST_WAIT_TRIG: begin
            if (force_i)
              force_pend_q <= 1'b1;
            if (trig_fire) begin
              trig_addr_o  <= addr_q;
              // DEPTH-1-pretrig further samples complete the window.
              post_left_q  <= ~pretrig_q;
              force_pend_q <= 1'b0;
              state_q      <= ST_POST;
            end
          end
          ST_POST: begin
            if (post_left_q == '0)
              state_q <= ST_DONE;
            else if (do_write)
              post_left_q <= post_left_q - 1'b1;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef TRIG_AUTO_EN
  localparam int TO_W = $clog2(AUTO_TIMEOUT + 1);

  logic [TO_W-1:0] to_cnt_q;
  logic            trig_auto_q;

  assign auto_due = (to_cnt_q == TO_W'(AUTO_TIMEOUT));

  // The counter is held at zero outside WAIT_TRIG, which restarts the
  // timeout on every entry.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      to_cnt_q    <= '0;
      trig_auto_q <= 1'b0;
    end else begin
      if (arm_ok)
        trig_auto_q <= 1'b0;
      if (state_q != ST_WAIT_TRIG || abort_i) begin
        to_cnt_q <= '0;
      end else if (do_write) begin
        if (trig_fire && auto_due && !hit && !force_i && !force_pend_q)
          trig_auto_q <= 1'b1;
        if (!auto_due)
          to_cnt_q <= to_cnt_q + 1'b1;
      end
    end
  end

  assign trig_auto_o = trig_auto_q;
`else
  assign auto_due    = 1'b0;
  assign trig_auto_o = 1'b0;
`endif

  assign state_o = state_q;
  assign busy_o  = capturing;
  assign done_o  = (state_q == ST_DONE);

endmodule

// File: tb/tb_trigger_capture_ctrl.sv
module tb_trigger_capture_ctrl;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int AUTO_TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rstn;
  logic [DATA_W-1:0] sample_i;
  logic              sample_valid_i;
  logic              arm_i;
  logic              abort_i;
  logic              force_i;
  logic [DATA_W-1:0] level_i;
  logic              edge_sel_i;
  logic [ADDR_W-1:0] pretrig_i;
  logic              wr_en_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [DATA_W-1:0] wr_data_o;
  logic [ADDR_W-1:0] trig_addr_o;
  logic [2:0]        state_o;
  logic              busy_o;
  logic              done_o;
  logic              trig_auto_o;

  trigger_capture_ctrl #(
    .DATA_W       (DATA_W),
    .ADDR_W       (ADDR_W),
    .AUTO_TIMEOUT (AUTO_TIMEOUT)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .sample_i       (sample_i),
    .sample_valid_i (sample_valid_i),
    .arm_i          (arm_i),
    .abort_i        (abort_i),
    .force_i        (force_i),
    .level_i        (level_i),
    .edge_sel_i     (edge_sel_i),
    .pretrig_i      (pretrig_i),
    .wr_en_o        (wr_en_o),
    .wr_addr_o      (wr_addr_o),
    .wr_data_o      (wr_data_o),
    .trig_addr_o    (trig_addr_o),
    .state_o        (state_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .trig_auto_o    (trig_auto_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  // Write-port monitor: every buffer write must match the next expected one.
  always @(negedge clk) begin
    if (wr_en_o) begin
      wr_t e;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL wr_port: unexpected write addr=%0d data=%0d", wr_addr_o, wr_data_o);
      end else begin
        e = exp_q.pop_front();
        if (wr_addr_o !== e.addr || wr_data_o !== e.data) begin
          n_err++;
          $display("FAIL wr_port: got addr=%0d data=%0d, expected addr=%0d data=%0d",
                   wr_addr_o, wr_data_o, e.addr, e.data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DATA_W-1:0] d);
    sample_i       = d;
    sample_valid_i = 1'b1;
    @(posedge clk);
    #1;
    sample_valid_i = 1'b0;
  endtask

  task automatic send_wr(input logic [DATA_W-1:0] d, input int a);
    wr_t e;
    e.addr = ADDR_W'(a);
    e.data = d;
    exp_q.push_back(e);
    send(d);
  endtask

  task automatic arm(input int pt);
    pretrig_i = ADDR_W'(pt);
    arm_i     = 1'b1;
    @(posedge clk);
    #1;
    arm_i     = 1'b0;
  endtask

  task automatic do_abort();
    abort_i = 1'b1;
    @(posedge clk);
    #1;
    abort_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 1'b0; sample_i = '0; sample_valid_i = 1'b0; arm_i = 1'b0;
    abort_i = 1'b0; force_i = 1'b0; level_i = '0; edge_sel_i = 1'b0; pretrig_i = '0;
    tick(2);
    check("rst_state", state_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_wr_en", wr_en_o, 0);
    check("rst_wr_addr", wr_addr_o, 0);
    check("rst_trig_addr", trig_addr_o, 0);
    check("rst_trig_auto", trig_auto_o, 0);
    rstn = 1'b1;
    tick(1);

    // Rising ramp, pretrig 4, level 100
    level_i = 16'd100; edge_sel_i = 1'b0;
    send(16'd999);                       // ignored in IDLE
    arm(4);
    check("a_state_prefill", state_o, 1);
    check("a_busy", busy_o, 1);
    send_wr(16'd0, 0); send_wr(16'd20, 1); send_wr(16'd40, 2);
    check("a_still_prefill", state_o, 1);
    send_wr(16'd60, 3);
    check("a_wait_after_4", state_o, 2);
    send_wr(16'd80, 4);
    check("a_no_trig_80", state_o, 2);
    send_wr(16'd100, 5);
    check("a_post", state_o, 3);
    check("a_trig_addr", trig_addr_o, 5);
    for (int k = 0; k < 11; k++) send_wr(16'(120 + 20 * k), (6 + k) % 16);
    tick(2);
    check("a_done_state", state_o, 4);
    check("a_done_o", done_o, 1);
    check("a_busy_done", busy_o, 0);
    send(16'd777);                       // ignored in DONE
    tick(1);
    check("a_q_drained", exp_q.size(), 0);

    // Falling, level 50: 50 must not trigger, 40 must
    level_i = 16'd50; edge_sel_i = 1'b1;
    arm(0);
    check("b_wait", state_o, 2);
    check("b_done_cleared", done_o, 0);
    send_wr(16'd80, 0); send_wr(16'd60, 1); send_wr(16'd50, 2);
    check("b_no_trig_50", state_o, 2);
    send_wr(16'd40, 3);
    check("b_post", state_o, 3);
    check("b_trig_addr", trig_addr_o, 3);
    // abort with arm and a sample in the same cycle during POST
    abort_i = 1'b1; arm_i = 1'b1; sample_i = 16'd33; sample_valid_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0; arm_i = 1'b0; sample_valid_i = 1'b0;
    check("b_abort_idle", state_o, 0);
    check("b_abort_busy", busy_o, 0);
    check("b_abort_wr_en", wr_en_o, 0);
    send(16'd44);
    tick(1);

    // pretrig 0, first sample above level, then force
    level_i = 16'd100; edge_sel_i = 1'b0;
    arm(0);
    send_wr(16'd150, 0);
    check("c_first_no_trig", state_o, 2);
    force_i = 1'b1;
    @(posedge clk); #1;
    force_i = 1'b0;
    check("c_force_pending_wait", state_o, 2);
    send_wr(16'd5, 1);
    check("c_forced_post", state_o, 3);
    check("c_trig_addr", trig_addr_o, 1);
    for (int k = 0; k < 15; k++) send_wr(16'(200 + k), (2 + k) % 16);
    tick(2);
    check("c_done", done_o, 1);

`ifdef TRIG_AUTO_EN
    // Constant 10 under level 100: auto trigger on the 9th sample
    arm(0);
    for (int k = 0; k < 8; k++) send_wr(16'd10, k);
    check("d_no_trig_8", state_o, 2);
    check("d_auto_low", trig_auto_o, 0);
    send_wr(16'd10, 8);
    check("d_auto_post", state_o, 3);
    check("d_auto_trig_addr", trig_addr_o, 8);
    check("d_auto_flag", trig_auto_o, 1);
    do_abort();
    check("d_auto_held", trig_auto_o, 1);
`else
    // Constant 10 under level 100: never triggers
    arm(0);
    for (int k = 0; k < 100; k++) send_wr(16'd10, k % 16);
    check("d_still_wait", state_o, 2);
    check("d_auto_tied", trig_auto_o, 0);
    do_abort();
`endif

    // Largest pretrig, then reset just after the trigger
    level_i = 16'd100; edge_sel_i = 1'b0;
    arm(15);
    check("e_prefill", state_o, 1);
    check("e_auto_cleared", trig_auto_o, 0);
    for (int k = 0; k < 15; k++) send_wr(16'(k), k);
    check("e_wait", state_o, 2);
    send_wr(16'd200, 15);
    check("e_post", state_o, 3);
    check("e_trig_addr", trig_addr_o, 15);
    rstn = 1'b0;
    @(posedge clk); #1;
    check("e_rst_state", state_o, 0);
    check("e_rst_wr_en", wr_en_o, 0);
    check("e_rst_wr_addr", wr_addr_o, 0);
    check("e_rst_wr_data", wr_data_o, 0);
    check("e_rst_trig_addr", trig_addr_o, 0);
    check("e_rst_busy", busy_o, 0);
    check("e_rst_done", done_o, 0);
    check("e_rst_auto", trig_auto_o, 0);
    rstn = 1'b1;
    tick(1);
    arm(2);
    send_wr(16'd7, 0);
    check("e_rearm_prefill", state_o, 1);
    tick(2);
    check("final_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
